// File: rtl/acq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acq_pkg
// Description : Shared types and constants for the ping-pong acquisition
//               packer: state enum, word markers and the words-per-set helper.
//               Optional macro ACQ_SEQ_TAG_EN adds a sequence header word to
//               every sample-set.
// Revision    : 1.0 - initial release
// ============================================================================
package acq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } acq_state_e;

    localparam logic [3:0] MARKER     = 4'hF;
    localparam logic [3:0] SEQ_MARKER = 4'hA;

`ifdef ACQ_SEQ_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif

    // One word per nibble of a sample, plus the header word when tagging.
    function automatic int words_per_set(input int data_width);
        return (data_width / 4) + (TAG_EN ? 1 : 0);
    endfunction

endpackage : acq_pkg
`default_nettype wire

// File: rtl/acq_serializer.sv
`default_nettype none
// ============================================================================
// Module      : acq_serializer
// Description : Latches one sample-set on load and then emits one packed
//               16-bit word per cycle together with its index inside the set.
//               With ACQ_SEQ_TAG_EN defined, index 0 is the {4'hA, seq} header.
// Ports       : clk, rst_n       - clock, async active-low reset
//               load             - capture ch*_in/seq_in (ignored while active)
//               ch1_in..ch3_in   - channel samples
//               seq_in           - sequence number for the header word
//               active           - word/idx are valid this cycle
//               idx              - word index within the set
//               word             - packed word
// Revision    : 1.0 - initial release
// ============================================================================
module acq_serializer
    import acq_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int N_CH       = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] ch1_in,
    input  logic [DATA_WIDTH-1:0] ch2_in,
    input  logic [DATA_WIDTH-1:0] ch3_in,
    input  logic [11:0]           seq_in,
    output logic                  active,
    output logic [2:0]            idx,
    output logic [15:0]           word
);

    localparam int         NIB      = DATA_WIDTH / 4;
    localparam int         WPS      = words_per_set(DATA_WIDTH);
    localparam logic [2:0] C_LAST   = 3'(WPS - 1);
    localparam logic [2:0] C_NIB_M1 = 3'(NIB - 1);
    localparam logic [2:0] C_OFS    = 3'(TAG_EN);

    logic [DATA_WIDTH-1:0] r_ch1, r_ch2, r_ch3;
    logic [11:0]           r_seq;
    logic                  r_active;
    logic [2:0]            r_idx;

    logic [2:0] w_k, w_nib;
    logic [3:0] w_n1, w_n2, w_n3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch1    <= '0;
            r_ch2    <= '0;
            r_ch3    <= '0;
            r_seq    <= '0;
            r_active <= 1'b0;
            r_idx    <= '0;
        end else if (load && !r_active) begin
            r_ch1    <= ch1_in;
            // Channels beyond N_CH are forced to zero so their nibble slots read 0.
            r_ch2    <= (N_CH >= 2) ? ch2_in : '0;
            r_ch3    <= (N_CH >= 3) ? ch3_in : '0;
            r_seq    <= seq_in;
            r_active <= 1'b1;
            r_idx    <= '0;
        end else if (r_active) begin
            if (r_idx == C_LAST) begin
                r_active <= 1'b0;
            end else begin
                r_idx <= r_idx + 3'd1;
            end
        end
    end

    // Data word k carries nibble NIB-1-k of each channel (MSB nibble first).
    always_comb begin
        w_k   = r_idx - C_OFS;
        w_nib = C_NIB_M1 - w_k;
        w_n1  = '0;
        w_n2  = '0;
        w_n3  = '0;
        for (int i = 0; i < NIB; i++) begin
            if (w_nib == 3'(i)) begin
                w_n1 = r_ch1[4*i +: 4];
                w_n2 = r_ch2[4*i +: 4];
                w_n3 = r_ch3[4*i +: 4];
            end
        end
        if (TAG_EN && (r_idx == 3'd0)) begin
            word = {SEQ_MARKER, r_seq};
        end else begin
            word = {MARKER, w_n1, w_n2, w_n3};
        end
    end

    assign active = r_active;
    assign idx    = r_idx;

endmodule : acq_serializer
`default_nettype wire

// File: rtl/acq_pingpong_packer.sv
`default_nettype none
// ============================================================================
// Module      : acq_pingpong_packer
// Description : Captures up to three ADC channels on sample_en, packs each
//               sample-set into marker-tagged 16-bit words and stores them in a
//               two-bank ping-pong buffer read out over valid/ready.
//               Optional macro ACQ_SEQ_TAG_EN: prepend {4'hA, seq} per set.
// Ports       : clk, rst_n            - clock, async active-low reset
//               start, stop           - acquisition control pulses
//               sample_en, data_in_*  - capture strobe and channel samples
//               out_data/valid/ready  - packed word stream
//               busy, done            - RUN/FLUSH, flush complete
//               overflow, drop_cnt    - sticky drop flag, saturating count
// Revision    : 1.0 - initial release
// ============================================================================
module acq_pingpong_packer
    import acq_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int N_CH       = 3,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  sample_en,
    input  logic [DATA_WIDTH-1:0] data_in_1,
    input  logic [DATA_WIDTH-1:0] data_in_2,
    input  logic [DATA_WIDTH-1:0] data_in_3,
    output logic [15:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [15:0]           drop_cnt
);

    localparam int            WPS    = words_per_set(DATA_WIDTH);
    localparam int            AW     = $clog2(DEPTH);
    localparam logic [AW:0]   C_HALF = (AW+1)'(DEPTH / 2);
    localparam logic [AW:0]   C_WPS  = (AW+1)'(WPS);
    localparam logic [AW-1:0] C_WPSW = AW'(WPS);

    acq_state_e r_state, w_state_nx;

    logic          r_wb, r_rb;          // bank being written / being read
    logic [AW-1:0] r_wcnt;              // words reserved in the write bank
    logic [1:0]    r_full;              // bank handed to the reader
    logic [AW-1:0] r_len [2];
    logic [AW-1:0] r_rd_ptr;
    logic          r_out_last;
    logic          r_set_bank;
    logic [AW-2:0] r_set_base;
    logic [11:0]   r_seq;
    logic [15:0]   mem [DEPTH];

    logic          w_ser_active;
    logic [2:0]    w_ser_idx;
    logic [15:0]   w_ser_word;
    logic [AW:0]   w_free;
    logic          w_start_acq, w_sample, w_fits, w_other_free;
    logic          w_accept_here, w_accept_swap, w_accept, w_drop, w_flush_close;
    logic          w_fetch, w_out_accept, w_bank_done, w_drained;
    logic [AW-2:0] w_wr_off;

    assign w_start_acq   = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_sample      = sample_en && (r_state == RUN);
    assign w_free        = C_HALF - {1'b0, r_wcnt};
    assign w_fits        = (w_free >= C_WPS);
    assign w_other_free  = !r_full[~r_wb];
    // Space is reserved at acceptance; the serializer must be idle so the
    // previous set is fully written before a bank can be handed over.
    assign w_accept_here = w_sample && !w_ser_active && w_fits;
    assign w_accept_swap = w_sample && !w_ser_active && !w_fits && w_other_free;
    assign w_accept      = w_accept_here || w_accept_swap;
    assign w_drop        = w_sample && !w_accept;
    assign w_flush_close = (r_state == FLUSH) && !w_ser_active && (r_wcnt != '0) && w_other_free;

    assign w_fetch       = r_full[r_rb] && (r_rd_ptr < r_len[r_rb]) && (!out_valid || out_ready);
    assign w_out_accept  = out_valid && out_ready;
    assign w_bank_done   = w_out_accept && r_out_last;
    assign w_drained     = !w_ser_active && (r_wcnt == '0) && (r_full == 2'b00) && !out_valid;
    assign w_wr_off      = r_set_base + (AW-1)'(w_ser_idx);

    acq_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .N_CH       (N_CH)
    ) u_ser (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (w_accept),
        .ch1_in (data_in_1),
        .ch2_in (data_in_2),
        .ch3_in (data_in_3),
        .seq_in (r_seq),
        .active (w_ser_active),
        .idx    (w_ser_idx),
        .word   (w_ser_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            IDLE:    if (start) w_state_nx = RUN;
            RUN: begin
                busy = 1'b1;
                if (stop) w_state_nx = FLUSH;
            end
            FLUSH: begin
                busy = 1'b1;
                if (w_drained) w_state_nx = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) w_state_nx = RUN;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_ser_active) mem[{r_set_bank, w_wr_off}] <= w_ser_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb       <= 1'b0;
            r_rb       <= 1'b0;
            r_wcnt     <= '0;
            r_full     <= 2'b00;
            r_len[0]   <= '0;
            r_len[1]   <= '0;
            r_rd_ptr   <= '0;
            r_set_bank <= 1'b0;
            r_set_base <= '0;
            r_seq      <= '0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            r_out_last <= 1'b0;
        end else if (w_start_acq) begin
            r_wb       <= 1'b0;
            r_rb       <= 1'b0;
            r_wcnt     <= '0;
            r_full     <= 2'b00;
            r_rd_ptr   <= '0;
            r_seq      <= '0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            if (w_accept_here) begin
                r_set_bank <= r_wb;
                r_set_base <= r_wcnt[AW-2:0];
                r_wcnt     <= r_wcnt + C_WPSW;
            end else if (w_accept_swap || w_flush_close) begin
                r_full[r_wb] <= 1'b1;
                r_len[r_wb]  <= r_wcnt;
                r_wb         <= ~r_wb;
                r_set_bank   <= ~r_wb;
                r_set_base   <= '0;
                r_wcnt       <= w_accept_swap ? C_WPSW : '0;
            end
            if (w_accept) r_seq <= r_seq + 12'd1;
            if (w_drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end

            if (w_fetch) begin
                out_data   <= mem[{r_rb, r_rd_ptr[AW-2:0]}];
                out_valid  <= 1'b1;
                r_out_last <= ((r_rd_ptr + 1'b1) == r_len[r_rb]);
                r_rd_ptr   <= r_rd_ptr + 1'b1;
            end else if (w_out_accept) begin
                out_valid  <= 1'b0;
            end
            // Bank is released only once its final word has been taken.
            if (w_bank_done) begin
                r_full[r_rb] <= 1'b0;
                r_rb         <= ~r_rb;
                r_rd_ptr     <= '0;
            end
        end
    end

endmodule : acq_pingpong_packer
`default_nettype wire

// File: tb/tb_acq_pingpong_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_acq_pingpong_packer
// Description : Directed self-checking bench for acq_pingpong_packer
//               (DATA_WIDTH=12, N_CH=3, DEPTH=16). Works with or without
//               ACQ_SEQ_TAG_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acq_pingpong_packer;

    localparam int DW  = 12;
    localparam int NIB = DW / 4;
`ifdef ACQ_SEQ_TAG_EN
    localparam int TAG = 1;
`else
    localparam int TAG = 0;
`endif
    localparam int WPS = NIB + TAG;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, stop = 1'b0, sample_en = 1'b0;
    logic [DW-1:0] d1 = '0, d2 = '0, d3 = '0;
    logic [15:0]   out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy, done, overflow;
    logic [15:0]   drop_cnt;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [15:0]   exp_q[$];
    logic [15:0]   got_log[$];
    logic [11:0]   model_seq;
    logic          stall_pending = 1'b0;
    logic [15:0]   stall_data;

    acq_pingpong_packer #(.DATA_WIDTH(DW), .N_CH(3), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .sample_en(sample_en), .data_in_1(d1), .data_in_2(d2), .data_in_3(d3),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected stream for one accepted set, built straight from the word format.
    task automatic model_push(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
        logic [DW-1:0] sa, sb, sc;
        if (TAG != 0) begin
            exp_q.push_back({4'hA, model_seq});
            model_seq = model_seq + 12'd1;
        end
        for (int k = 0; k < NIB; k++) begin
            sa = a >> (4 * (NIB - 1 - k));
            sb = b >> (4 * (NIB - 1 - k));
            sc = c >> (4 * (NIB - 1 - k));
            exp_q.push_back({4'hF, sa[3:0], sb[3:0], sc[3:0]});
        end
    endtask

    // Single compare process: every handshake word against the model, and
    // stability of a stalled word.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_pending = 1'b0;
        end else begin
            if (stall_pending) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_data", {16'd0, out_data}, {16'd0, stall_data});
            end
            stall_pending = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", {16'd0, out_data}, 32'hFFFF_FFFF);
                    end else begin
                        check("word", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
                    end
                    got_log.push_back(out_data);
                end else begin
                    stall_pending = 1'b1;
                    stall_data    = out_data;
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_acq();
        start = 1'b1; step(); start = 1'b0;
        model_seq = 12'd0;
    endtask

    task automatic stop_acq();
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    task automatic sample(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] c, input bit accepted, input int gap);
        d1 = a; d2 = b; d3 = c;
        sample_en = 1'b1; step(); sample_en = 1'b0;
        if (accepted) model_push(a, b, c);
        step(gap);
    endtask

    task automatic wait_done(input bit toggle);
        int cyc;
        cyc = 0;
        while (!done && cyc < 400) begin
            if (toggle) out_ready = ~out_ready;
            step();
            cyc++;
        end
        check("done_timeout", {31'd0, done}, 32'd1);
        out_ready = 1'b1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        step(3);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        rst_n = 1'b1;
        step(2);

        // ---------------- basic packing ----------------
        got_log.delete();
        start_acq();
        check("basic_busy", {31'd0, busy}, 32'd1);
        sample(12'hABC, 12'h123, 12'h456, 1'b1, 6);
        stop_acq();
        out_ready = 1'b1;
        wait_done(1'b0);
        check("basic_count", got_log.size(), WPS);
        if (TAG != 0) begin
            check("basic_hdr", {16'd0, got_log[0]}, 32'hA000);
        end
        check("basic_w0", {16'd0, got_log[TAG]}, 32'hFA14);
        check("basic_w1", {16'd0, got_log[TAG+1]}, 32'hFB25);
        check("basic_w2", {16'd0, got_log[TAG+2]}, 32'hFC36);
        check("basic_busy_end", {31'd0, busy}, 32'd0);
        check("basic_drop", {16'd0, drop_cnt}, 32'd0);

        // ---------------- bank close and swap ----------------
        got_log.delete();
        out_ready = 1'b0;
        start_acq();
        check("swap_done_clr", {31'd0, done}, 32'd0);
        sample(12'h111, 12'h222, 12'h333, 1'b1, 6);
        sample(12'h444, 12'h555, 12'h666, 1'b1, 6);
        sample(12'h789, 12'hDEF, 12'h0A5, 1'b1, 6);
        check("swap_handed", {31'd0, out_valid}, 32'd1);
        check("swap_overflow", {31'd0, overflow}, 32'd0);
        out_ready = 1'b1;
        step(20);
        check("swap_bank0_len", got_log.size(), 2 * WPS);
        if (TAG != 0) begin
            check("tag_hdr0", {16'd0, got_log[0]}, 32'hA000);
            check("tag_hdr1", {16'd0, got_log[WPS]}, 32'hA001);
        end
        stop_acq();
        wait_done(1'b0);
        check("swap_total", got_log.size(), 3 * WPS);
        check("swap_drop", {16'd0, drop_cnt}, 32'd0);
        check("swap_q_empty", exp_q.size(), 0);

        // ---------------- overflow + back-pressure ----------------
        got_log.delete();
        out_ready = 1'b0;
        start_acq();
        sample(12'h0F1, 12'h1E2, 12'h2D3, 1'b1, 6);
        sample(12'h3C4, 12'h4B5, 12'h5A6, 1'b1, 6);
        sample(12'h697, 12'h788, 12'h879, 1'b1, 6);
        sample(12'h96A, 12'hA5B, 12'hB4C, 1'b1, 6);
        sample(12'hFFF, 12'hEEE, 12'hDDD, 1'b0, 6);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        check("ovf_drop_cnt", {16'd0, drop_cnt}, 32'd1);
        stop_acq();
        wait_done(1'b1);
        check("ovf_total", got_log.size(), 4 * WPS);
        check("ovf_q_empty", exp_q.size(), 0);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);

        // ---------------- serializer collision ----------------
        got_log.delete();
        start_acq();
        check("coll_ovf_clr", {31'd0, overflow}, 32'd0);
        check("coll_drop_clr", {16'd0, drop_cnt}, 32'd0);
        sample(12'h135, 12'h246, 12'h357, 1'b1, 0);
        sample(12'h9AB, 12'h8BC, 12'h7CD, 1'b0, 6);
        check("coll_drop_cnt", {16'd0, drop_cnt}, 32'd1);
        check("coll_overflow", {31'd0, overflow}, 32'd1);
        stop_acq();
        wait_done(1'b0);
        check("coll_total", got_log.size(), WPS);

        // ---------------- reset mid-readout ----------------
        got_log.delete();
        out_ready = 1'b0;
        start_acq();
        sample(12'h101, 12'h202, 12'h303, 1'b1, 6);
        sample(12'h404, 12'h505, 12'h606, 1'b1, 6);
        sample(12'h707, 12'h808, 12'h909, 1'b1, 6);
        check("rstmid_pre_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_valid", {31'd0, out_valid}, 32'd0);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        step(2);
        rst_n = 1'b1;
        step();
        got_log.delete();
        out_ready = 1'b1;
        start_acq();
        sample(12'hC3A, 12'h5E7, 12'h19D, 1'b1, 6);
        stop_acq();
        wait_done(1'b0);
        check("rstmid_total", got_log.size(), WPS);
        check("rstmid_w0", {16'd0, got_log[TAG]}, 32'hFC51);
        check("rstmid_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_acq_pingpong_packer
`default_nettype wire
